// File: rtl/mem_resp_stage.sv
// mem_resp_stage: in-order MEM stage that holds up to DEPTH loads, stores and ALU ops until their data arrives.
// Latency: an entry reaches WB one cycle after its data_ok (same cycle for the head entry when MS_RDATA_BYPASS_EN is defined).
// Backpressure: ms_allowin = !full; the head is held with a stable result while ws_allowin=0.
//
// Ports: clk/reset (async, active-high); EX side es_* with es_to_ms_valid/ms_allowin;
//        data_sram_data_ok/rdata are in-order responses; ms_flush discards every entry;
//        WB side ms_to_ws_valid/ws_allowin plus ws_pc/ws_result/ws_dest/ws_gr_we;
//        ms_fwd_bus has 40 bits per entry {valid, gr_we, dest[4:0], ready, result[31:0]}, entry 0 = head;
//        ms_resp_err is sticky and set by a data_ok that nothing was waiting for.
// Optional feature: define MS_RDATA_BYPASS_EN so a data_ok for the head entry makes it ready combinationally.
module mem_resp_stage #(
   parameter int DEPTH      = 2,
   parameter bit FWD_EN_ALL = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                es_to_ms_valid,
   output logic                ms_allowin,
   input  logic [31:0]         es_pc,
   input  logic [31:0]         es_alu_result,
   input  logic [4:0]          es_dest,
   input  logic                es_gr_we,
   input  logic                es_res_from_mem,
   input  logic [4:0]          es_ld_op,
   input  logic                es_mem_req,
   input  logic [1:0]          es_addr_lowbits,
   input  logic                data_sram_data_ok,
   input  logic [31:0]         data_sram_rdata,
   input  logic                ms_flush,
   input  logic                ws_allowin,
   output logic                ms_to_ws_valid,
   output logic [31:0]         ws_pc,
   output logic [31:0]         ws_result,
   output logic [4:0]          ws_dest,
   output logic                ws_gr_we,
   output logic [DEPTH*40-1:0] ms_fwd_bus,
   output logic                ms_resp_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = 8;
   localparam int EW = 40;

   // control state, cleared by reset
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] got_q, got_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    disc_q, disc_d;
   logic             err_q, err_d;

   // payload, qualified by vld_q so never reset
   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      pc_d    [DEPTH];
   logic [31:0]      alu_q   [DEPTH];
   logic [31:0]      alu_d   [DEPTH];
   logic [31:0]      rdata_q [DEPTH];
   logic [31:0]      rdata_d [DEPTH];
   logic [4:0]       dest_q  [DEPTH];
   logic [4:0]       dest_d  [DEPTH];
   logic [4:0]       op_q    [DEPTH];
   logic [4:0]       op_d    [DEPTH];
   logic [1:0]       low_q   [DEPTH];
   logic [1:0]       low_d   [DEPTH];
   logic [DEPTH-1:0] gr_we_q, gr_we_d;
   logic [DEPTH-1:0] rfm_q, rfm_d;
   logic [DEPTH-1:0] mreq_q, mreq_d;

   logic [PW-1:0]    age_slot [DEPTH];
   logic             resp_found;
   logic [PW-1:0]    resp_slot;
   logic [CW-1:0]    awaiting;
   logic             disc_hit, fill, spurious;
   logic             head_byp, head_rdy;
   logic [31:0]      head_data;
   logic             enq, deq;

   // Load data extraction; halfword selection ignores lowbits[0] since misalignment faults in EX.
   function automatic logic [31:0] ld_extract(input logic [4:0]  op,
                                              input logic [1:0]  low,
                                              input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (low)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = low[1] ? d[31:16] : d[15:0];
      case (op)
         5'b00010: r = {{24{b[7]}}, b};
         5'b00100: r = {24'd0, b};
         5'b01000: r = {{16{h[15]}}, h};
         5'b10000: r = {16'd0, h};
         default:  r = d;
      endcase
      return r;
   endfunction

   // age_slot[i] is the slot of the i-th oldest entry
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_slot[i] = head_q + PW'(i);
      end
   end

   // Oldest entry still waiting for its response, and how many are waiting.
   always_comb begin
      resp_found = 1'b0;
      resp_slot  = head_q;
      awaiting   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[age_slot[i]] && mreq_q[age_slot[i]] && !got_q[age_slot[i]]) begin
            awaiting = awaiting + CW'(1);
            if (!resp_found) begin
               resp_found = 1'b1;
               resp_slot  = age_slot[i];
            end
         end
      end
   end

   // Responses belonging to flushed entries are swallowed before any live entry is filled.
   assign disc_hit = data_sram_data_ok && (disc_q != '0);
   assign fill     = data_sram_data_ok && (disc_q == '0) && resp_found;
   assign spurious = data_sram_data_ok && (disc_q == '0) && !resp_found;

`ifdef MS_RDATA_BYPASS_EN
   assign head_byp = fill && (resp_slot == head_q);
`else
   assign head_byp = 1'b0;
`endif

   assign head_rdy       = !mreq_q[head_q] || got_q[head_q] || head_byp;
   assign head_data      = head_byp ? data_sram_rdata : rdata_q[head_q];
   assign ms_allowin     = (cnt_q != CW'(DEPTH));
   assign ms_to_ws_valid = vld_q[head_q] && head_rdy && !ms_flush;
   assign ws_pc          = pc_q[head_q];
   assign ws_dest        = dest_q[head_q];
   assign ws_gr_we       = gr_we_q[head_q];
   assign ws_result      = rfm_q[head_q] ? ld_extract(op_q[head_q], low_q[head_q], head_data)
                                         : alu_q[head_q];
   assign ms_resp_err    = err_q;

   assign enq = es_to_ms_valid && ms_allowin && !ms_flush;
   assign deq = ms_to_ws_valid && ws_allowin;

   always_comb begin
      ms_fwd_bus = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ms_fwd_bus[i*EW +: EW] = {
            vld_q[age_slot[i]] && (FWD_EN_ALL || (i == 0)),
            gr_we_q[age_slot[i]],
            dest_q[age_slot[i]],
            (i == 0) ? head_rdy : (!mreq_q[age_slot[i]] || got_q[age_slot[i]]),
            rfm_q[age_slot[i]]
               ? ld_extract(op_q[age_slot[i]], low_q[age_slot[i]],
                            (i == 0) ? head_data : rdata_q[age_slot[i]])
               : alu_q[age_slot[i]]};
      end
   end

   always_comb begin
      vld_d   = vld_q;
      got_d   = got_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      disc_d  = disc_q;
      err_d   = err_q | spurious;
      pc_d    = pc_q;
      alu_d   = alu_q;
      rdata_d = rdata_q;
      dest_d  = dest_q;
      op_d    = op_q;
      low_d   = low_q;
      gr_we_d = gr_we_q;
      rfm_d   = rfm_q;
      mreq_d  = mreq_q;

      if (disc_hit) begin
         disc_d = disc_q - DW'(1);
      end
      if (fill) begin
         got_d[resp_slot]   = 1'b1;
         rdata_d[resp_slot] = data_sram_rdata;
      end
      if (deq) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end
      // the tail slot is never the fill slot: fill targets a valid entry, tail is empty
      if (enq) begin
         vld_d[tail_q]   = 1'b1;
         got_d[tail_q]   = 1'b0;
         pc_d[tail_q]    = es_pc;
         alu_d[tail_q]   = es_alu_result;
         dest_d[tail_q]  = es_dest;
         op_d[tail_q]    = es_ld_op;
         low_d[tail_q]   = es_addr_lowbits;
         gr_we_d[tail_q] = es_gr_we;
         rfm_d[tail_q]   = es_res_from_mem;
         mreq_d[tail_q]  = es_mem_req;
         tail_d          = tail_q + PW'(1);
      end
      if (enq && !deq) begin
         cnt_d = cnt_q + CW'(1);
      end else if (deq && !enq) begin
         cnt_d = cnt_q - CW'(1);
      end

      // Every response still owed to the flushed entries must be swallowed later;
      // one arriving in the flush cycle itself is already accounted for.
      if (ms_flush) begin
         vld_d  = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
         disc_d = disc_q + DW'(awaiting) - DW'(disc_hit || fill);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q  <= '0;
         got_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         disc_q <= '0;
         err_q  <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         got_q  <= got_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         disc_q <= disc_d;
         err_q  <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      dest_q  <= dest_d;
      op_q    <= op_d;
      low_q   <= low_d;
      gr_we_q <= gr_we_d;
      rfm_q   <= rfm_d;
      mreq_q  <= mreq_d;
   end

endmodule

// File: tb/tb_mem_resp_stage.sv
module tb_mem_resp_stage;
   localparam int DEPTH = 2;
   localparam int EW    = 40;
`ifdef MS_RDATA_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset;
   logic                es_to_ms_valid, ms_allowin;
   logic [31:0]         es_pc, es_alu_result;
   logic [4:0]          es_dest;
   logic                es_gr_we, es_res_from_mem;
   logic [4:0]          es_ld_op;
   logic                es_mem_req;
   logic [1:0]          es_addr_lowbits;
   logic                data_sram_data_ok;
   logic [31:0]         data_sram_rdata;
   logic                ms_flush, ws_allowin, ms_to_ws_valid;
   logic [31:0]         ws_pc, ws_result;
   logic [4:0]          ws_dest;
   logic                ws_gr_we;
   logic [DEPTH*EW-1:0] ms_fwd_bus;
   logic                ms_resp_err;

   always #5 clk = ~clk;

   mem_resp_stage #(.DEPTH(DEPTH), .FWD_EN_ALL(1'b1)) dut (
      .clk(clk), .reset(reset),
      .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_pc(es_pc), .es_alu_result(es_alu_result), .es_dest(es_dest),
      .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem), .es_ld_op(es_ld_op),
      .es_mem_req(es_mem_req), .es_addr_lowbits(es_addr_lowbits),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .ms_flush(ms_flush), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
      .ws_pc(ws_pc), .ws_result(ws_result), .ws_dest(ws_dest), .ws_gr_we(ws_gr_we),
      .ms_fwd_bus(ms_fwd_bus), .ms_resp_err(ms_resp_err));

   // reference model: an ordered list of in-flight instructions
   typedef struct packed {
      logic [31:0] pc, alu, data;
      logic [4:0]  dest, op;
      logic        gr_we, rfm, mreq, got;
      logic [1:0]  low;
   } ent_t;

   ent_t q[$];
   int   disc;
   logic err_m;
   logic exp_valid;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_extract(input logic [4:0] op, input logic [1:0] low,
                                             input logic [31:0] d);
      int unsigned b, h;
      b = (d >> (8 * int'(low))) % 256;
      h = (d >> (16 * int'(low[1]))) % 65536;
      case (op)
         5'b00010: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         5'b00100: return b;
         5'b01000: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         5'b10000: return h;
         default:  return d;
      endcase
   endfunction

   function automatic int oldest();
      for (int i = 0; i < q.size(); i++)
         if (q[i].mreq && !q[i].got) return i;
      return -1;
   endfunction

   function automatic int awaiting();
      int n = 0;
      for (int i = 0; i < q.size(); i++)
         if (q[i].mreq && !q[i].got) n++;
      return n;
   endfunction

   function automatic logic [31:0] eresult(input ent_t e, input logic byp);
      return e.rfm ? m_extract(e.op, e.low, byp ? data_sram_rdata : e.data) : e.alu;
   endfunction

   task automatic model_check();
      int oi;
      logic byp, rdy;
      logic [EW-1:0] f;
      oi = oldest();
      exp_valid = 1'b0;
      chk("allowin", 32'(ms_allowin), 32'(q.size() < DEPTH));
      chk("resp_err", 32'(ms_resp_err), 32'(err_m));
      for (int i = 0; i < DEPTH; i++) begin
         f = ms_fwd_bus[i*EW +: EW];
         if (i < q.size()) begin
            byp = BYP && (i == 0) && data_sram_data_ok && (disc == 0) && (oi == 0);
            rdy = !q[i].mreq || q[i].got || byp;
            chk("fwd_valid", 32'(f[39]), 32'd1);
            chk("fwd_gr_we", 32'(f[38]), 32'(q[i].gr_we));
            chk("fwd_dest", 32'(f[37:33]), 32'(q[i].dest));
            chk("fwd_ready", 32'(f[32]), 32'(rdy));
            if (rdy) chk("fwd_result", f[31:0], eresult(q[i], byp));
            if (i == 0) exp_valid = rdy && !ms_flush;
         end else begin
            chk("fwd_valid", 32'(f[39]), 32'd0);
         end
      end
      chk("ms_to_ws_valid", 32'(ms_to_ws_valid), 32'(exp_valid));
      if (exp_valid) begin
         chk("ws_pc", ws_pc, q[0].pc);
         chk("ws_result", ws_result,
             eresult(q[0], BYP && data_sram_data_ok && (disc == 0) && (oi == 0)));
         chk("ws_dest", 32'(ws_dest), 32'(q[0].dest));
         chk("ws_gr_we", 32'(ws_gr_we), 32'(q[0].gr_we));
      end
   endtask

   task automatic model_step();
      int d0, aw, oi;
      bit cons, enq, deq;
      ent_t e;
      d0 = disc; aw = awaiting(); oi = oldest();
      enq = es_to_ms_valid && (q.size() < DEPTH) && !ms_flush;
      deq = exp_valid && ws_allowin;
      cons = 0;
      if (data_sram_data_ok) begin
         if (disc > 0) begin
            disc--; cons = 1;
         end else if (oi >= 0) begin
            e = q[oi]; e.got = 1'b1; e.data = data_sram_rdata; q[oi] = e; cons = 1;
         end else begin
            err_m = 1'b1;
         end
      end
      if (ms_flush) begin
         q.delete();
         disc = d0 + aw - int'(cons);
      end else begin
         if (deq) e = q.pop_front();
         if (enq) begin
            e.pc = es_pc; e.alu = es_alu_result; e.data = '0; e.dest = es_dest;
            e.op = es_ld_op; e.gr_we = es_gr_we; e.rfm = es_res_from_mem;
            e.mreq = es_mem_req; e.got = 1'b0; e.low = es_addr_lowbits;
            q.push_back(e);
         end
      end
   endtask

   task automatic model_clear();
      q.delete(); disc = 0; err_m = 1'b0;
   endtask

   task automatic tick();
      #1;
      model_check();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0; ms_flush = 1'b0;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                       input logic gr_we, input logic rfm, input logic [4:0] op,
                       input logic mreq, input logic [1:0] low);
      es_to_ms_valid = 1'b1; es_pc = pc; es_alu_result = alu; es_dest = dest;
      es_gr_we = gr_we; es_res_from_mem = rfm; es_ld_op = op; es_mem_req = mreq;
      es_addr_lowbits = low; data_sram_data_ok = 1'b0; ms_flush = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_allowin"}, 32'(ms_allowin), 32'd1);
      chk({tag, "_valid"}, 32'(ms_to_ws_valid), 32'd0);
      chk({tag, "_err"}, 32'(ms_resp_err), 32'd0);
      for (int i = 0; i < DEPTH; i++)
         chk({tag, "_fwd_valid"}, 32'(ms_fwd_bus[i*EW+39]), 32'd0);
   endtask

   logic [4:0]    t_op  [3] = '{5'b00010, 5'b00100, 5'b10000};
   logic [1:0]    t_low [3] = '{2'd3, 2'd3, 2'd2};
   logic [31:0]   t_exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
   logic [EW-1:0] f1, f0;

   initial begin
      reset = 1'b1; ws_allowin = 1'b0; idle();
      send(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'b00001, 1'b0, 2'd0); es_to_ms_valid = 1'b0;
      data_sram_rdata = '0;
      model_clear();
      @(negedge clk); @(negedge clk);
      #1; reset_checks("rst");
      reset = 1'b0;
      @(negedge clk);
      #1; reset_checks("post_rst");

      // load extraction examples
      for (int k = 0; k < 3; k++) begin
         ws_allowin = 1'b0;
         send(32'h1000 + 32'(k * 4), 32'h2003, 5'd3, 1'b1, 1'b1, t_op[k], 1'b1, t_low[k]); tick();
         idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234; tick();
         idle(); ws_allowin = 1'b1; #1;
         chk("ext_valid", 32'(ms_to_ws_valid), 32'd1);
         chk("ext_result", ws_result, t_exp[k]);
         tick();
      end
      idle(); tick();

      // fill to DEPTH, in-order delivery
      ws_allowin = 1'b0;
      send(32'h2000, 32'h40, 5'd1, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      send(32'h2004, 32'h44, 5'd2, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      send(32'h2008, 32'h48, 5'd3, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); #1;
      chk("full_allowin", 32'(ms_allowin), 32'd0);
      tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11; tick();
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h22; tick();
      idle(); ws_allowin = 1'b1; #1;
      chk("order_first", ws_result, 32'h11);
      chk("order_first_pc", ws_pc, 32'h2000);
      tick(); #1;
      chk("order_second", ws_result, 32'h22);
      chk("order_second_pc", ws_pc, 32'h2004);
      tick(); #1;
      chk("order_empty", 32'(ms_to_ws_valid), 32'd0);

      // WB stall holds the result
      ws_allowin = 1'b0;
      send(32'h3000, 32'h0, 5'd9, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A_0001; tick();
      idle();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_valid", 32'(ms_to_ws_valid), 32'd1);
         chk("stall_result", ws_result, 32'h5A5A_0001);
         tick();
      end
      ws_allowin = 1'b1; tick(); #1;
      chk("stall_drained", 32'(ms_to_ws_valid), 32'd0);

      // flush with a response in the same cycle, then discard
      send(32'h4000, 32'h0, 5'd4, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      send(32'h4004, 32'h0, 5'd5, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      idle(); ms_flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0; tick();
      idle(); #1;
      chk("flush_valid", 32'(ms_to_ws_valid), 32'd0);
      chk("flush_allowin", 32'(ms_allowin), 32'd1);
      ws_allowin = 1'b0;
      send(32'h4008, 32'h0, 5'd6, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD; tick();
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h600D; tick();
      idle(); ws_allowin = 1'b1; #1;
      chk("disc_valid", 32'(ms_to_ws_valid), 32'd1);
      chk("disc_result", ws_result, 32'h600D);
      chk("disc_pc", ws_pc, 32'h4008);
      chk("disc_err", 32'(ms_resp_err), 32'd0);
      tick();

      // ALU op behind a pending load
      send(32'h5000, 32'h0, 5'd4, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      send(32'h5004, 32'hA1B2_C3D4, 5'd7, 1'b1, 1'b0, 5'b00001, 1'b0, 2'd0); tick();
      idle(); #1;
      f1 = ms_fwd_bus[EW +: EW];
      f0 = ms_fwd_bus[0 +: EW];
      chk("alu_not_first", 32'(ms_to_ws_valid), 32'd0);
      chk("fwd1_valid", 32'(f1[39]), 32'd1);
      chk("fwd1_ready", 32'(f1[32]), 32'd1);
      chk("fwd1_result", f1[31:0], 32'hA1B2_C3D4);
      chk("fwd1_dest", 32'(f1[37:33]), 32'd7);
      chk("fwd0_ready", 32'(f0[32]), 32'd0);
      tick(); tick();
      ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h77; tick();
      idle(); ws_allowin = 1'b1; #1;
      chk("alu_load_pc", ws_pc, 32'h5000);
      chk("alu_load_result", ws_result, 32'h77);
      tick(); #1;
      chk("alu_second_valid", 32'(ms_to_ws_valid), 32'd1);
      chk("alu_second_pc", ws_pc, 32'h5004);
      chk("alu_second_result", ws_result, 32'hA1B2_C3D4);
      tick();

      // response-to-WB latency
      ws_allowin = 1'b0;
      send(32'h6000, 32'h0, 5'd8, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h66; #1;
      chk("lat_same_cycle", 32'(ms_to_ws_valid), 32'(BYP));
      tick(); idle(); #1;
      chk("lat_next_cycle", 32'(ms_to_ws_valid), 32'd1);
      ws_allowin = 1'b1; tick();

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         logic mr, isld;
         mr   = 1'($urandom_range(0, 1));
         isld = mr && ($urandom_range(0, 3) != 0);
         es_to_ms_valid    = 1'($urandom_range(0, 1));
         es_pc             = $urandom;
         es_alu_result     = $urandom;
         es_dest           = 5'($urandom);
         es_gr_we          = mr ? isld : 1'($urandom);
         es_res_from_mem   = isld;
         es_ld_op          = 5'(1 << $urandom_range(0, 4));
         es_mem_req        = mr;
         es_addr_lowbits   = 2'($urandom);
         data_sram_data_ok = ((disc + awaiting()) > 0) && ($urandom_range(0, 1) == 1);
         data_sram_rdata   = $urandom;
         ms_flush          = ($urandom_range(0, 31) == 0);
         ws_allowin        = ($urandom_range(0, 3) != 0);
         tick();
      end

      // drain, then a response nobody asked for
      idle(); ws_allowin = 1'b1;
      for (int k = 0; k < 300 && (q.size() > 0 || disc > 0); k++) begin
         data_sram_data_ok = ((disc + awaiting()) > 0);
         data_sram_rdata   = $urandom;
         tick();
      end
      idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hEEEE; tick();
      idle(); #1;
      chk("spurious_err", 32'(ms_resp_err), 32'd1);
      tick(); tick(); tick(); #1;
      chk("spurious_sticky", 32'(ms_resp_err), 32'd1);

      // asynchronous reset with work in flight
      ws_allowin = 1'b0;
      send(32'h7000, 32'h0, 5'd1, 1'b1, 1'b1, 5'b00001, 1'b1, 2'd0); tick();
      send(32'h7004, 32'h7, 5'd2, 1'b1, 1'b0, 5'b00001, 1'b0, 2'd0); tick();
      idle(); reset = 1'b1; #1;
      reset_checks("async_rst");
      model_clear();
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      ws_allowin = 1'b1;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
